arcade_ce_gen: RTL and testbench
================================

// Module: arcade_ce_gen
// PURPOSE
// - Parametrised pixel clock-enable generator for arcade cores. Replaces fixed /2 or /4 counters at the top level.
// - Produces ce_pix and ce_half from a fractional NUM/DEN phase accumulator, with two selectable rates
//   (native and scandoubled).
// - Rate changes take effect only at a frame boundary, or after a timeout, so no line is emitted with mixed pixel widths.
// PARAMETERS
// - ACC_W      16      accumulator width; DEN must be < 2**ACC_W
// - DEN        4       ratio denominator (clk cycles per NUM pixels)
// - NUM_LO     1       numerator for native rate (default clk/4); 1 <= NUM_LO <= DEN
// - NUM_HI     2       numerator for high rate (default clk/2); 1 <= NUM_HI <= DEN
// - TIMEOUT    1048576 clks without frame_sync edge before pending switch is forced; must be >= 1
// PORTS
// - clk          in   1  core clock; all logic on rising edge
// - reset_n      in   1  asynchronous, active-low reset
// - hi_rate_req  in   1  requested rate: 1=NUM_HI, 0=NUM_LO; quasi-static, level
// - frame_sync   in   1  VSync from video timing; rising edge marks frame boundary
// - ce_pix       out  1  one-clk pixel enable pulse
// - ce_half      out  1  one-clk pulse on every second ce_pix
// - hi_rate      out  1  rate currently applied
// - switched     out  1  one-clk pulse in the cycle a rate change is applied
// BEHAVIOUR
// - Reset: acc=0, ce_pix=0, ce_half=0, hi_rate=0, switched=0, half_ph=0, timeout cnt=0, sync flops=0, fs_d=0.
// - Request input: hi_rate_req passes through a 2-flop synchroniser to give req_s.
//   - pending = (req_s != hi_rate).
// - Frame edge: fs_d is frame_sync registered; fs_rise = frame_sync & ~fs_d.
// - Accumulator: inc = hi_rate ? NUM_HI : NUM_LO; sum = acc + inc, computed ACC_W+1 bits wide (no overflow).
//   - If sum >= DEN: ce_pix<=1, acc<=sum-DEN.
//   - Else: ce_pix<=0, acc<=sum.
//   - ce_pix is registered. With NUM=1, DEN=4 it pulses on the 4th, 8th, 12th... clk edge after reset release.
//   - NUM=DEN gives ce_pix high every cycle.
// - ce_half: on each cycle where ce_pix is set to 1, half_ph toggles and ce_half<=half_ph (old value).
//   - ce_half is therefore set on the 2nd, 4th, ... ce_pix.
//   - ce_half is 0 whenever ce_pix is 0.
// - Switch control, 2 states:
//   - IDLE: pending=0; timeout cnt held at 0.
//   - WAIT: pending=1; cnt increments each clk, saturating at TIMEOUT.
//   - Apply condition: in WAIT, and (fs_rise or cnt==TIMEOUT).
//   - On apply: hi_rate<=req_s, switched<=1, acc<=0, half_ph<=0, ce_pix<=0, ce_half<=0, cnt<=0.
//   - Apply has priority over an accumulator wrap in the same cycle; that pulse is dropped.
//   - After apply, the first ce_pix at the new rate follows exactly as after reset.
// - Request withdrawn in WAIT (req_s returns to hi_rate): back to IDLE, cnt<=0, no apply, switched stays 0.
// - fs_rise in IDLE: no effect on acc or phase (no re-sync of an unchanged rate).
// - Reset asserted mid-operation: all state returns to reset values immediately (async); no pulse on any output.
// TESTING
// - Default params, hi_rate_req=0, no frame_sync:
//   ce_pix on edges 4,8,12,16; ce_half on 8 and 16 only; hi_rate=0.
// - DEN=5, NUM_LO=2:
//   ce_pix pattern over 10 clks is exactly 4 pulses, on edges 3,5,8,10; repeats with period 5.
// - hi_rate_req 0->1 mid-frame:
//   hi_rate stays 0 until first frame_sync rise after req_s=1; that cycle switched=1, acc=0.
//   ce_pix then every 2nd clk.
// - Request raised then dropped before a frame_sync rise:
//   switched never asserts; hi_rate stays 0; cadence unbroken.
// - TIMEOUT=100, frame_sync tied 0, req 0->1:
//   switched pulses exactly 100 clks after WAIT entered; hi_rate=1.
// - Apply cycle coincides with accumulator wrap:
//   ce_pix=0 that cycle.
// - reset_n pulsed low for 1 clk mid-stream:
//   outputs 0 at once; cadence restarts at edge 4.

Source files
------------

// File: rtl/arcade_ce_gen.sv
// arcade_ce_gen: fractional pixel clock-enable generator for arcade cores.
// A NUM/DEN phase accumulator produces ce_pix, and ce_half marks every second
// ce_pix. Two numerators give a native and a scandoubled rate. A rate change
// is held back until a frame boundary (or a timeout), so that no line is
// drawn with mixed pixel widths.
module arcade_ce_gen #(
  parameter int ACC_W   = 16,
  parameter int DEN     = 4,
  parameter int NUM_LO  = 1,
  parameter int NUM_HI  = 2,
  parameter int TIMEOUT = 1048576
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hi_rate_req,
  input  logic frame_sync,
  output logic ce_pix,
  output logic ce_half,
  output logic hi_rate,
  output logic switched
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [ACC_W:0] DEN_C    = (ACC_W + 1)'(DEN);
  localparam logic [ACC_W:0] NUM_LO_C = (ACC_W + 1)'(NUM_LO);
  localparam logic [ACC_W:0] NUM_HI_C = (ACC_W + 1)'(NUM_HI);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             fs_prev_q, fs_prev_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_pix_q, ce_pix_d;
  logic             ce_half_q, ce_half_d;
  logic             half_ph_q, half_ph_d;
  logic             hi_rate_q, hi_rate_d;
  logic             switched_q, switched_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             req_s;
  logic             pending;
  logic             fs_rise;
  logic             apply;
  logic             wrap;
  logic [ACC_W:0]   inc;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   acc_next;

  // Next-state logic: synchroniser, frame edge detect, switch control and accumulator.
  always_comb begin
    sync1_d    = hi_rate_req;
    sync2_d    = sync1_q;
    fs_prev_d  = frame_sync;

    req_s      = sync2_q;
    pending    = (req_s != hi_rate_q);
    fs_rise    = frame_sync & ~fs_prev_q;

    inc        = hi_rate_q ? NUM_HI_C : NUM_LO_C;
    sum        = {1'b0, acc_q} + inc;
    wrap       = (sum >= DEN_C);
    acc_next   = wrap ? (sum - DEN_C) : sum;

    apply      = (state_q == ST_WAIT) && pending && (fs_rise || (cnt_q == TIMEOUT_C));

    acc_d      = acc_q;
    ce_pix_d   = 1'b0;
    ce_half_d  = 1'b0;
    half_ph_d  = half_ph_q;
    hi_rate_d  = hi_rate_q;
    switched_d = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;

    if (apply) begin
      // A rate change restarts the cadence from zero; any wrap this cycle is dropped.
      acc_d      = '0;
      half_ph_d  = 1'b0;
      hi_rate_d  = req_s;
      switched_d = 1'b1;
      state_d    = ST_IDLE;
      cnt_d      = '0;
    end else begin
      acc_d    = acc_next[ACC_W-1:0];
      ce_pix_d = wrap;
      if (wrap) begin
        half_ph_d = ~half_ph_q;
        ce_half_d = half_ph_q;
      end
      if (pending) begin
        state_d = ST_WAIT;
        cnt_d   = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      fs_prev_q  <= 1'b0;
      acc_q      <= '0;
      ce_pix_q   <= 1'b0;
      ce_half_q  <= 1'b0;
      half_ph_q  <= 1'b0;
      hi_rate_q  <= 1'b0;
      switched_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      fs_prev_q  <= fs_prev_d;
      acc_q      <= acc_d;
      ce_pix_q   <= ce_pix_d;
      ce_half_q  <= ce_half_d;
      half_ph_q  <= half_ph_d;
      hi_rate_q  <= hi_rate_d;
      switched_q <= switched_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ce_pix   = ce_pix_q;
  assign ce_half  = ce_half_q;
  assign hi_rate  = hi_rate_q;
  assign switched = switched_q;

endmodule

// File: tb/tb_arcade_ce_gen.sv
// tb_arcade_ce_gen: scoreboard bench for arcade_ce_gen.
// Three instances share the clock and reset: default parameters, a fractional
// DEN=5/NUM_LO=2 ratio, and a short TIMEOUT=100. Outputs are sampled on the
// falling edge; edge numbers count rising edges after reset release.
module tb_arcade_ce_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic req_a = 1'b0, fs_a = 1'b0;
  logic req_b = 1'b0, fs_b = 1'b0;
  logic req_c = 1'b0, fs_c = 1'b0;
  logic pix_a, half_a, hi_a, sw_a;
  logic pix_b, half_b, hi_b, sw_b;
  logic pix_c, half_c, hi_c, sw_c;

  int checks = 0;
  int passed = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  arcade_ce_gen dut (
    .clk(clk), .reset_n(reset_n), .hi_rate_req(req_a), .frame_sync(fs_a),
    .ce_pix(pix_a), .ce_half(half_a), .hi_rate(hi_a), .switched(sw_a)
  );

  arcade_ce_gen #(.DEN(5), .NUM_LO(2)) dut_frac (
    .clk(clk), .reset_n(reset_n), .hi_rate_req(req_b), .frame_sync(fs_b),
    .ce_pix(pix_b), .ce_half(half_b), .hi_rate(hi_b), .switched(sw_b)
  );

  arcade_ce_gen #(.TIMEOUT(100)) dut_to (
    .clk(clk), .reset_n(reset_n), .hi_rate_req(req_c), .frame_sync(fs_c),
    .ce_pix(pix_c), .ce_half(half_c), .hi_rate(hi_c), .switched(sw_c)
  );

  // Pulse reset and release it on a falling edge so the next rising edge is edge 1.
  task automatic do_reset();
    reset_n = 1'b0;
    req_a = 1'b0; fs_a = 1'b0;
    req_b = 1'b0; fs_b = 1'b0;
    req_c = 1'b0; fs_c = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Push the expected vector for a run where the rate switches at edge a_edge.
  task automatic push_switch_run(input int n, input int a_edge);
    for (int e = 1; e <= n; e++) begin
      if (e < a_edge)
        exp_q.push_back({(e % 4 == 0), (e % 8 == 0), 1'b0, 1'b0});
      else if (e == a_edge)
        exp_q.push_back(4'b0011);
      else
        exp_q.push_back({((e - a_edge) % 2 == 0), ((e - a_edge) % 4 == 0), 1'b1, 1'b0});
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0000);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_a, half_a, hi_a, sw_a} !== exp_v)
        $display("[TB] FAIL reset_a got=%b exp=%b", {pix_a, half_a, hi_a, sw_a}, exp_v);
      else passed++;
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_b, half_b, hi_b, sw_b} !== exp_v)
        $display("[TB] FAIL reset_b got=%b exp=%b", {pix_b, half_b, hi_b, sw_b}, exp_v);
      else passed++;
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_c, half_c, hi_c, sw_c} !== exp_v)
        $display("[TB] FAIL reset_c got=%b exp=%b", {pix_c, half_c, hi_c, sw_c}, exp_v);
      else passed++;
    end
  endtask

  task automatic test_cadence();
    logic [3:0] exp_v;
    do_reset();
    for (int e = 1; e <= 16; e++)
      exp_q.push_back({(e % 4 == 0), (e % 8 == 0), 1'b0, 1'b0});
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_a, half_a, hi_a, sw_a} !== exp_v)
        $display("[TB] FAIL cadence e%0d got=%b exp=%b", e, {pix_a, half_a, hi_a, sw_a}, exp_v);
      else passed++;
    end
  endtask

  task automatic test_fractional();
    logic [3:0] exp_v;
    do_reset();
    for (int e = 1; e <= 15; e++)
      exp_q.push_back({((e % 5 == 3) || (e % 5 == 0)), (e % 5 == 0), 1'b0, 1'b0});
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_b, half_b, hi_b, sw_b} !== exp_v)
        $display("[TB] FAIL fractional e%0d got=%b exp=%b", e, {pix_b, half_b, hi_b, sw_b}, exp_v);
      else passed++;
    end
  endtask

  task automatic test_withdraw();
    logic [3:0] exp_v;
    do_reset();
    for (int e = 1; e <= 16; e++)
      exp_q.push_back({(e % 4 == 0), (e % 8 == 0), 1'b0, 1'b0});
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_a, half_a, hi_a, sw_a} !== exp_v)
        $display("[TB] FAIL withdraw e%0d got=%b exp=%b", e, {pix_a, half_a, hi_a, sw_a}, exp_v);
      else passed++;
      if (e == 2)  req_a = 1'b1;
      if (e == 6)  req_a = 1'b0;
      if (e == 10) fs_a  = 1'b1;
      if (e == 12) fs_a  = 1'b0;
    end
  endtask

  task automatic test_switch_frame();
    logic [3:0] exp_v;
    do_reset();
    push_switch_run(18, 10);
    for (int e = 1; e <= 18; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_a, half_a, hi_a, sw_a} !== exp_v)
        $display("[TB] FAIL switch_frame e%0d got=%b exp=%b", e, {pix_a, half_a, hi_a, sw_a}, exp_v);
      else passed++;
      if (e == 2)  req_a = 1'b1;
      if (e == 9)  fs_a  = 1'b1;
      if (e == 11) fs_a  = 1'b0;
    end
  endtask

  task automatic test_apply_wrap();
    logic [3:0] exp_v;
    do_reset();
    push_switch_run(20, 12);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_a, half_a, hi_a, sw_a} !== exp_v)
        $display("[TB] FAIL apply_wrap e%0d got=%b exp=%b", e, {pix_a, half_a, hi_a, sw_a}, exp_v);
      else passed++;
      if (e == 2)  req_a = 1'b1;
      if (e == 11) fs_a  = 1'b1;
      if (e == 13) fs_a  = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_v;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pix_a === 1'b1 && hi_a === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("[TB] FAIL reset_mid_setup got=no_hi_rate_pulse exp=pulse_within_4_clks");
    end
    exp_q.push_back(4'b0000);
    req_a = 1'b0;
    reset_n = 1'b0;
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pix_a, half_a, hi_a, sw_a} !== exp_v)
      $display("[TB] FAIL reset_mid_async got=%b exp=%b", {pix_a, half_a, hi_a, sw_a}, exp_v);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 12; e++)
      exp_q.push_back({(e % 4 == 0), (e % 8 == 0), 1'b0, 1'b0});
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_a, half_a, hi_a, sw_a} !== exp_v)
        $display("[TB] FAIL reset_mid e%0d got=%b exp=%b", e, {pix_a, half_a, hi_a, sw_a}, exp_v);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_v;
    do_reset();
    push_switch_run(112, 105);
    for (int e = 1; e <= 112; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if ({pix_c, half_c, hi_c, sw_c} !== exp_v)
        $display("[TB] FAIL timeout e%0d got=%b exp=%b", e, {pix_c, half_c, hi_c, sw_c}, exp_v);
      else passed++;
      if (e == 2) req_c = 1'b1;
    end
  endtask

  // Test sequence.
  initial begin
    #1;
    test_reset();
    test_cadence();
    test_fractional();
    test_withdraw();
    test_apply_wrap();
    test_reset_mid();
    test_switch_frame();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Watchdog against a stuck simulation.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
